// File: rtl/fifo_sync.sv
// Single-clock valid/ready FIFO with first-word fall-through, occupancy, almost-full,
// synchronous flush and high-water-mark tracking.
module fifo_sync #(
  parameter int WIDTH    = 15,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic [CW-1:0]    max_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  // Status is decoded from the registered count only, so no input reaches an output.
  assign in_ready    = (count != CW'(DEPTH));
  assign out_valid   = (count != '0);
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign out_data    = out_valid ? mem[rd_ptr] : '0;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_level <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (count_nxt > max_level) max_level <= count_nxt;
    end
  end

  // Flush leaves storage untouched; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: directed vectors on the 15x4 default build and
// a random valid/ready run on a 8x16 build against a reference occupancy model.
module tb_fifo_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic        a_in_ready, a_out_valid, a_almost_full;
  logic [14:0] a_in_data = '0, a_out_data;
  logic [2:0]  a_count, a_max_level;

  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic        b_in_ready, b_out_valid, b_almost_full;
  logic [7:0]  b_in_data = '0, b_out_data;
  logic [4:0]  b_count, b_max_level;

  fifo_sync #(.WIDTH(15), .DEPTH(4), .AF_LEVEL(3)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count), .almost_full(a_almost_full), .max_level(a_max_level));

  fifo_sync #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .almost_full(b_almost_full), .max_level(b_max_level));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [14:0] qa[$];
  logic [7:0]  qb[$];
  int          a_popped = 0;

  // Output monitors: compare whenever a pop handshake is about to happen.
  always @(negedge clk) begin
    if (rst && !a_flush && a_out_valid && a_out_ready) begin
      a_popped++;
      if (qa.size() == 0) chk("a_unexpected_word", 32'(a_out_data), 32'hdead);
      else chk("a_data", 32'(a_out_data), 32'(qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_word", 32'(b_out_data), 32'hdead);
      else chk("b_data", 32'(b_out_data), 32'(qb.pop_front()));
    end
  end

  // Reference occupancy model for the random run.
  bit b_run = 0;
  int m_cnt = 0;
  int m_max = 0;
  always @(negedge clk) begin
    bit p_push, p_pop;
    if (rst && b_run) begin
      chk("b_count", 32'(b_count), 32'(m_cnt));
      chk("b_almost_full", 32'(b_almost_full), 32'(m_cnt >= 12));
      chk("b_max_level", 32'(b_max_level), 32'(m_max));
      p_push = b_in_valid && (m_cnt != 16);
      p_pop  = b_out_ready && (m_cnt != 0);
      if (p_push) qb.push_back(b_in_data);
      m_cnt = m_cnt + int'(p_push) - int'(p_pop);
      if (m_cnt > m_max) m_max = m_cnt;
    end
  end

  initial begin
    #3;
    chk("rst_count", 32'(a_count), 0);
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_in_ready", 32'(a_in_ready), 1);
    chk("rst_out_data", 32'(a_out_data), 0);
    chk("rst_max_level", 32'(a_max_level), 0);
    chk("rst_almost_full", 32'(a_almost_full), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Fill to full with the consumer stalled.
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1; a_in_data = 15'(i); qa.push_back(15'(i));
      tick();
      if (i == 1) begin
        chk("fill1_out_valid", 32'(a_out_valid), 1);
        chk("fill1_out_data", 32'(a_out_data), 32'h1);
      end
      if (i == 2) chk("fill2_almost_full", 32'(a_almost_full), 0);
      if (i == 3) chk("fill3_almost_full", 32'(a_almost_full), 1);
      if (i == 4) begin
        chk("fill4_in_ready", 32'(a_in_ready), 0);
        chk("fill4_count", 32'(a_count), 4);
      end
    end
    a_in_data = 15'h5;
    tick();
    chk("refused_count", 32'(a_count), 4);
    a_in_valid = 0; a_out_ready = 1;
    repeat (4) tick();
    a_out_ready = 0;
    chk("drain_out_valid", 32'(a_out_valid), 0);
    chk("drain_max_level", 32'(a_max_level), 4);
    chk("drain_popped", 32'(a_popped), 4);

    // Streaming with one word resident: 21 words, several pointer wraps.
    a_in_valid = 1; a_in_data = 15'd100; qa.push_back(15'd100);
    tick();
    a_out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      a_in_data = 15'(101 + k); qa.push_back(15'(101 + k));
      tick();
      chk("stream_count", 32'(a_count), 1);
    end
    a_in_valid = 0;
    tick();
    a_out_ready = 0;
    chk("stream_empty", 32'(a_count), 0);
    chk("stream_popped", 32'(a_popped), 25);

    // Full with simultaneous pop: push refused, then accepted.
    a_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      a_in_data = 15'(200 + i); qa.push_back(15'(200 + i));
      tick();
    end
    chk("full_count", 32'(a_count), 4);
    a_in_data = 15'd204; a_out_ready = 1;
    tick();
    chk("full_pop_count", 32'(a_count), 3);
    a_out_ready = 0; qa.push_back(15'd204);
    tick();
    chk("refill_count", 32'(a_count), 4);
    chk("refill_in_ready", 32'(a_in_ready), 0);
    a_in_valid = 0; a_out_ready = 1;
    repeat (4) tick();
    a_out_ready = 0;
    chk("full_drain_count", 32'(a_count), 0);

    // Flush wins over a simultaneous push.
    a_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 15'(300 + i); qa.push_back(15'(300 + i));
      tick();
    end
    chk("preflush_count", 32'(a_count), 3);
    a_flush = 1; a_in_data = 15'd303; qa.delete();
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("flush_count", 32'(a_count), 0);
    chk("flush_out_valid", 32'(a_out_valid), 0);
    chk("flush_out_data", 32'(a_out_data), 0);
    chk("flush_max_level", 32'(a_max_level), 0);
    chk("flush_in_ready", 32'(a_in_ready), 1);
    tick();
    chk("postflush_count", 32'(a_count), 0);

    // Asynchronous reset with two words stored.
    a_in_valid = 1;
    a_in_data = 15'd400; qa.push_back(15'd400); tick();
    a_in_data = 15'd401; qa.push_back(15'd401); tick();
    a_in_valid = 0;
    chk("prereset_count", 32'(a_count), 2);
    #2;
    rst = 1'b0; qa.delete();
    #1;
    chk("async_rst_count", 32'(a_count), 0);
    chk("async_rst_out_valid", 32'(a_out_valid), 0);
    chk("async_rst_in_ready", 32'(a_in_ready), 1);
    chk("async_rst_out_data", 32'(a_out_data), 0);
    chk("async_rst_max_level", 32'(a_max_level), 0);
    tick();
    rst = 1'b1;
    tick();

    // Random stalls on the 8x16 build.
    b_run = 1;
    for (int c = 0; c < 2000; c++) begin
      b_in_valid  = ($urandom_range(0, 99) < 60);
      b_out_ready = ($urandom_range(0, 99) < 50);
      b_in_data   = 8'($urandom_range(0, 255));
      tick();
    end
    b_in_valid = 0; b_out_ready = 0;
    @(negedge clk);
    b_run = 0;
    #1;
    chk("a_queue_empty", 32'(qa.size()), 0);
    chk("b_max_level_final", 32'(b_max_level), 32'(m_max));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Parametrised single-clock FIFO with valid/ready handshakes on both sides.
- Successor to the fixed 4-deep, 15-bit delay line in the sample-buffering path:
  - configurable width and depth
  - flow control instead of an unconditional per-clock shift
  - occupancy reporting, almost-full warning, synchronous flush, high-water-mark tracking
- Sits between a bursty producer (sample front end) and a stallable consumer.

Parameters:
- WIDTH, 15, data word width in bits (>=1).
- DEPTH, 4, number of storage entries; power of two, >=2.
- AF_LEVEL, 3, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- CW (localparam), $clog2(DEPTH+1), width of count and max_level.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of contents; high for one or more cycles.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_data  input  WIDTH  write data.
- out_valid  output  1  out_data holds the oldest stored word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  WIDTH  head-of-queue data; 0 when out_valid=0.
- count  output  CW  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AF_LEVEL.
- max_level  output  CW  highest count reached since reset/flush.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately without a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0, max_level=0
  - all memory entries=0
  - out_valid=0, out_data=0, in_ready=1, almost_full=0 (0 unless AF_LEVEL... AF_LEVEL>=1, so 0)
- Reset release is clean on any cycle. Reset mid-operation discards all contents.
- Push: in_valid & in_ready at a rising edge. Writes mem[wr_ptr], wr_ptr += 1 (wraps DEPTH-1 -> 0).
- Pop: out_valid & out_ready at a rising edge. rd_ptr += 1 (wraps).
- in_ready = (count != DEPTH). Combinational from registered state; no dependency on out_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid, else 0.
  - First-word fall-through: a word pushed at edge N is on out_data with out_valid=1 immediately after edge N. Latency is one cycle.
- count update per edge: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
- Simultaneous push+pop when empty: impossible, since out_valid=0 means no pop; the push proceeds.
- Simultaneous push+pop when 0<count<DEPTH: both occur; count is unchanged; pointers both advance.
- in_valid while in_ready=0: word ignored, no state change. The producer must hold it.
- out_ready while out_valid=0: ignored.
- flush=1 at an edge:
  - wr_ptr, rd_ptr, count and max_level go to 0; out_valid=0 next cycle.
  - Flush overrides any push or pop in the same cycle. The word is not stored and no pop is counted.
  - Memory contents are not cleared.
- max_level: each edge without flush, max_level <= max(max_level, next count).
- almost_full: combinational from count.
- All outputs are derived from registers only; no combinational path from inputs to outputs.

Test Plan:
- Reset with DEPTH=4, WIDTH=15 -> count=0, out_valid=0, in_ready=1, out_data=0, max_level=0. Asserting rst mid-run with 2 words stored -> same values immediately, without a clock edge.
- Push 0x0001..0x0004 on consecutive cycles with out_ready=0:
  - after edge 1: out_valid=1, out_data=0x0001
  - after edge 3: almost_full=1
  - after edge 4: in_ready=0, count=4
  - fifth push of 0x0005 is ignored
  - then out_ready=1 for 4 cycles -> outputs 0x0001..0x0004 in order, then out_valid=0, max_level=4.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 words, starting with 1 word stored -> count stays 1, order is preserved across multiple pointer wraps, no word is lost or duplicated.
- Full plus simultaneous pop: count=4, in_valid=1, out_ready=1 -> push refused, count=3 next cycle; push accepted the following cycle -> count=4.
- Flush with count=3, in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, out_data=0, max_level=0, in_ready=1.
- Random valid/ready stalls, WIDTH=8, DEPTH=16, AF_LEVEL=12, 2000 cycles against a scoreboard queue:
  - data order is exact
  - count, almost_full and max_level match the model every cycle
